keypad_input_conditioner: RTL and testbench

//  Conditions the 10 raw DigiLock digit buttons (0..9) into a clean one-hot key vector.
//  The one-hot vector drives the decimal-to-BCD encoder stage directly.

---
 rtl/keypad_input_conditioner_pkg.sv | 25 ++
 rtl/keypad_input_conditioner_sync_2ff.sv | 25 ++
 rtl/keypad_input_conditioner.sv | 106 ++++++++++
 tb/tb_keypad_input_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_input_conditioner_pkg.sv
// Shared definitions for the DigiLock keypad conditioner:
// the number of digit buttons, the FSM state constants and
// a pair of small bit-pattern helpers.
package keypad_input_conditioner_pkg;

   localparam int NUM_KEYS = 10;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] PRESSED  = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   localparam logic [NUM_KEYS-1:0] KEYS_ONE = {{(NUM_KEYS-1){1'b0}}, 1'b1};

   // True when exactly one key line is set.
   function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
      return (v != '0) && ((v & (v - KEYS_ONE)) == '0);
   endfunction

   // True when two or more key lines are set.
   function automatic logic is_multi(input logic [NUM_KEYS-1:0] v);
      return (v & (v - KEYS_ONE)) != '0;
   endfunction

endpackage

// File: rtl/keypad_input_conditioner_sync_2ff.sv
// Two-stage synchroniser for a bundle of asynchronous input lines.
// Both stages clear to zero on reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Shift the raw lines through two flops to settle metastability.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_input_conditioner.sv
// Keypad input conditioner: synchronises the ten digit buttons,
// debounces press and release, rejects multi-key presses and
// emits a single key_valid pulse per accepted press.
module keypad_input_conditioner
   import keypad_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] raw_keys,
   output logic [NUM_KEYS-1:0] key_onehot,
   output logic                key_valid,
   output logic                multi_key,
   output logic                busy
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] sync_keys;
   logic [NUM_KEYS-1:0] cand;
   logic [CNT_W-1:0]    cnt;
   logic [1:0]          state;

   sync_2ff #(
      .WIDTH (NUM_KEYS)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (raw_keys),
      .q     (sync_keys)
   );

   // Press/release debounce FSM; also owns the candidate key, the
   // stability counter and the key outputs. The counter saturates at
   // its last value so it can never wrap back and fake a short count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         cand       <= '0;
         key_onehot <= '0;
         key_valid  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (is_one_hot(sync_keys)) begin
                  cand  <= sync_keys;
                  cnt   <= '0;
                  state <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (sync_keys == cand) begin
                  if (cnt == CNT_LAST) begin
                     key_onehot <= cand;
                     key_valid  <= 1'b1;
                     state      <= PRESSED;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            PRESSED: begin
               if (sync_keys != cand) begin
                  cnt   <= '0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               if (sync_keys == '0) begin
                  if (cnt == CNT_LAST) begin
                     key_onehot <= '0;
                     state      <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Registered status flag: more than one synchronised key is down.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         multi_key <= 1'b0;
      end else begin
         multi_key <= is_multi(sync_keys);
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_keypad_input_conditioner.sv
// Self-checking bench for keypad_input_conditioner: directed scenarios
// plus random button activity, compared every cycle against a
// run-length based behavioural model of press/release acceptance.
module tb_keypad_input_conditioner;

   localparam int D = 4;

   logic       clock;
   logic       reset;
   logic [9:0] raw_keys;
   logic [9:0] key_onehot;
   logic       key_valid;
   logic       multi_key;
   logic       busy;

   int assert_count = 0;
   int fail_count   = 0;

   // Model state: two-sample input delay, then a description of what
   // key is being tracked and how long its run has lasted.
   logic [9:0] m1, m2;
   logic [9:0] cand_key;
   logic [9:0] held_key;
   bit         releasing;
   int         streak;
   logic       exp_valid;
   logic       exp_multi;

   int phase_tick;
   int valid_count;
   int first_valid_tick;

   keypad_input_conditioner #(
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .raw_keys   (raw_keys),
      .key_onehot (key_onehot),
      .key_valid  (key_valid),
      .multi_key  (multi_key),
      .busy       (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      assert_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m1        = '0;
      m2        = '0;
      cand_key  = '0;
      held_key  = '0;
      releasing = 0;
      streak    = 0;
      exp_valid = 0;
      exp_multi = 0;
   endtask

   // A press is accepted once the same single key has been seen for
   // D+1 consecutive samples starting from idle; a release completes
   // after D all-zero samples following the first change away from the key.
   task automatic model_edge();
      logic [9:0] s;
      s         = m2;
      exp_valid = 0;
      exp_multi = ($countones(s) > 1);
      if (held_key == 0) begin
         if (cand_key != 0) begin
            if (s == cand_key) begin
               streak++;
               if (streak == D + 1) begin
                  held_key  = cand_key;
                  cand_key  = '0;
                  exp_valid = 1;
                  releasing = 0;
               end
            end else begin
               cand_key = '0;
            end
         end else if ($countones(s) == 1) begin
            cand_key = s;
            streak   = 1;
         end
      end else if (!releasing) begin
         if (s != held_key) begin
            releasing = 1;
            streak    = 0;
         end
      end else begin
         if (s == 0) begin
            streak++;
            if (streak == D) begin
               held_key  = '0;
               releasing = 0;
            end
         end else begin
            streak = 0;
         end
      end
      m2 = m1;
      m1 = raw_keys;
   endtask

   task automatic check_output();
      chk("key_onehot", key_onehot, held_key);
      chk("key_valid", {9'b0, key_valid}, {9'b0, exp_valid});
      chk("multi_key", {9'b0, multi_key}, {9'b0, exp_multi});
      chk("busy", {9'b0, busy}, {9'b0, (cand_key != 0) || (held_key != 0)});
      chk("onehot_legal", {9'b0, ($countones(key_onehot) <= 1)}, 10'd1);
   endtask

   task automatic start_phase();
      phase_tick       = 0;
      valid_count      = 0;
      first_valid_tick = 0;
   endtask

   // Drive one cycle of raw input, advance the model at the edge and
   // check the outputs half a cycle later.
   task automatic apply_stimulus(input logic [9:0] v);
      raw_keys = v;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_output();
      phase_tick++;
      if (key_valid) begin
         valid_count++;
         if (first_valid_tick == 0) first_valid_tick = phase_tick;
      end
   endtask

   task automatic hold(input logic [9:0] v, input int n);
      for (int i = 0; i < n; i++) apply_stimulus(v);
   endtask

   initial begin
      logic [9:0] pat;
      int         len;
      reset    = 1'b1;
      raw_keys = '0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      chk("reset_onehot", key_onehot, 10'h000);
      chk("reset_valid", {9'b0, key_valid}, 10'd0);
      chk("reset_multi", {9'b0, multi_key}, 10'd0);
      chk("reset_busy", {9'b0, busy}, 10'd0);
      reset = 1'b0;

      $display("[TB] single key press and release");
      start_phase();
      hold(10'h020, 20);
      chk("t1_valid_count", 10'(valid_count), 10'd1);
      chk("t1_valid_edge", 10'(first_valid_tick), 10'd7);
      chk("t1_key_held", key_onehot, 10'h020);
      hold(10'h000, 10);
      chk("t1_key_cleared", key_onehot, 10'h000);

      $display("[TB] bouncing press then stable hold");
      start_phase();
      for (int i = 0; i < 3; i++) begin
         hold(10'h008, 2);
         hold(10'h000, 2);
      end
      chk("t2_no_pulse_bounce", 10'(valid_count), 10'd0);
      start_phase();
      hold(10'h008, 10);
      chk("t2_valid_edge", 10'(first_valid_tick), 10'd7);
      chk("t2_valid_count", 10'(valid_count), 10'd1);
      hold(10'h000, 10);

      $display("[TB] two keys at once");
      start_phase();
      hold(10'h003, 2);
      chk("t3_multi_edge2", {9'b0, multi_key}, 10'd0);
      hold(10'h003, 1);
      chk("t3_multi_edge3", {9'b0, multi_key}, 10'd1);
      hold(10'h003, 7);
      chk("t3_no_pulse", 10'(valid_count), 10'd0);
      chk("t3_no_key", key_onehot, 10'h000);
      hold(10'h000, 4);

      $display("[TB] extra key during press");
      start_phase();
      hold(10'h008, 8);
      hold(10'h088, 5);
      chk("t4_first_key_kept", key_onehot, 10'h008);
      hold(10'h000, 10);
      chk("t4_single_pulse", 10'(valid_count), 10'd1);
      start_phase();
      hold(10'h200, 8);
      chk("t4_new_press_edge", 10'(first_valid_tick), 10'd7);
      chk("t4_new_key", key_onehot, 10'h200);
      hold(10'h000, 10);

      $display("[TB] short glitch");
      start_phase();
      hold(10'h100, 3);
      hold(10'h000, 6);
      chk("t5_no_pulse", 10'(valid_count), 10'd0);
      chk("t5_idle", {9'b0, busy}, 10'd0);

      $display("[TB] reset while pressed");
      start_phase();
      hold(10'h040, 8);
      chk("t6_pressed", key_onehot, 10'h040);
      #1 reset = 1'b1;
      #1;
      chk("t6_async_onehot", key_onehot, 10'h000);
      chk("t6_async_valid", {9'b0, key_valid}, 10'd0);
      chk("t6_async_busy", {9'b0, busy}, 10'd0);
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      start_phase();
      hold(10'h040, 9);
      chk("t6_repress_edge", 10'(first_valid_tick), 10'd7);
      hold(10'h000, 10);

      $display("[TB] random activity");
      for (int seg = 0; seg < 60; seg++) begin
         case ($urandom_range(0, 3))
            0:       pat = 10'h000;
            1, 2:    pat = 10'(1) << $urandom_range(0, 9);
            default: pat = (10'(1) << $urandom_range(0, 4)) | (10'(1) << $urandom_range(5, 9));
         endcase
         len = $urandom_range(1, 10);
         hold(pat, len);
      end
      hold(10'h000, 10);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
